pe_array_feeder: RTL and testbench
==================================

Name: pe_array_feeder

Overview:
- Transmit side of the systolic mesh ingress.
- Accepts one k-slice per handshake: column k of the A tile (one element per row) and row k of the B tile (one element per column).
- Emits the slices as skewed wavefronts on the mesh WEST (a_in_row) and NORTH (b_in_col) ports.
- Sequences the per-block control around the data: clear pulse before the first beat, drain pulse after the last MAC, done pulse once the serpentine drain has finished.

Parameters:
- W, mm_pkg::W: operand width.
- T, mm_pkg::T: mesh dimension.
- K_MAX, 256: maximum inner dimension per block.
- KW, $clog2(K_MAX+1): k_len width.
- PE_LAT, 1: PE multiply-accumulate latency in cycles (2 when PIPE_MUL).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a block (sampled in IDLE only)
- k_len  in  KW  inner dimension for this block
- in_valid  in  1  slice valid
- in_ready  out  1  slice accepted when in_valid && in_ready
- a_vec  in  T*W  A slice, element i goes to mesh row i
- b_vec  in  T*W  B slice, element j goes to mesh column j
- a_in_row  out  T*W  to mesh WEST ingress
- a_in_valid  out  T  per-row valid
- b_in_col  out  T*W  to mesh NORTH ingress
- b_in_valid  out  T  per-column valid
- acc_clear_block  out  1  one-cycle clear pulse
- drain_pulse  out  1  one-cycle drain injection
- busy  out  1  state != IDLE
- done  out  1  one-cycle block-complete pulse

Behaviour:
- Clocking and reset: single clock, asynchronous active-low reset. Every output is registered except in_ready and busy, which decode the state register.
- Reset values: all data outputs 0, all valids 0, acc_clear_block/drain_pulse/done 0, in_ready 0, busy 0, state IDLE, all skew stages cleared.
- FSM states: IDLE, CLEAR, STREAM, FLUSH, DRAIN, DONE.
  - IDLE: on start with k_len != 0, latch k_eff = min(k_len, K_MAX), clear k_cnt, go to CLEAR. start with k_len == 0 is ignored.
  - CLEAR: acc_clear_block = 1 for exactly this cycle, then STREAM.
  - STREAM: in_ready = 1. Each accepted beat increments k_cnt. The accept with k_cnt == k_eff-1 moves to FLUSH. in_ready stays 1 in the cycle of the final accept.
  - FLUSH: in_ready = 0, bubbles injected. Lasts exactly T-1+PE_LAT cycles, then DRAIN.
  - DRAIN: drain_pulse = 1 in the first cycle only. State lasts exactly T*T cycles, then DONE.
  - DONE: done = 1 for one cycle, then IDLE.
- start while busy is ignored. in_valid outside STREAM is ignored (no accept).
- Skew: mesh row i sees a beat accepted in cycle c as a_in_row[i] with a_in_valid[i] = 1 at cycle c+1+i. Column j similarly sees b_in_col[j], b_in_valid[j] at c+1+j.
  - Implementation: per-lane shift register of depth i (output register plus i stages).
  - Valid bits travel with the data.
  - A non-accept cycle (including all FLUSH/DRAIN cycles) shifts a bubble: valid 0, data 0.
- Beat gaps on the input are preserved exactly, each lane shifted by its skew.
- No backpressure from the mesh; the mesh consumes every cycle.
- Reset asserted mid-block: immediate return to IDLE, skew pipes flushed to zero. No done or drain_pulse is generated.
- k_cnt width KW. No wrap, since k_eff <= K_MAX.

Test Plan:
- Reset, then idle 10 cycles -> all outputs 0, busy 0, in_ready 0.
- T=4, PE_LAT=1, start with k_len=3, in_valid held 1, start seen at cycle 0 ->
  - acc_clear_block high at cycle 1; beats accepted at cycles 2, 3, 4.
  - a_in_valid[0] high at cycles 3-5; a_in_valid[3] high at cycles 6-8; b lanes identical.
  - drain_pulse at cycle 9; done at cycle 25.
- Same block with in_valid pattern 1,0,1,1 -> a_in_valid[2] shows 1,0,1,1 starting at cycle 5. Data a_vec[2] values 0x11, 0x22, 0x33 appear in order, with 0 in the bubble.
- start pulsed again at cycle 6 of the block, and a separate start with k_len=0 from IDLE -> both ignored: no second clear, busy stays 0 in the k_len=0 case.
- rst_n low during STREAM after 2 beats -> all valids 0 next cycle. No drain_pulse or done follows. A fresh start then behaves as the second scenario.
- K_MAX=4, k_len=7 -> exactly 4 beats accepted, then in_ready falls and FLUSH begins.

Source files
------------

// File: rtl/pe_array_feeder_if.sv
// Slice-ingress bundle for the mesh feeder: block start/length plus the A/B k-slice handshake.
// The feeder is the slave. It consumes start/k_len/in_valid/a_vec/b_vec and returns in_ready.
// The source is the master.
interface pe_array_feeder_if #(
   parameter int W  = 8,
   parameter int T  = 4,
   parameter int KW = 9
);
   logic          start;
   logic [KW-1:0] k_len;
   logic          in_valid;
   logic          in_ready;
   logic [T*W-1:0] a_vec;
   logic [T*W-1:0] b_vec;

   modport master (output start, k_len, in_valid, a_vec, b_vec, input in_ready);
   modport slave  (input start, k_len, in_valid, a_vec, b_vec, output in_ready);
endinterface

// File: rtl/pe_array_feeder.sv
// Systolic mesh ingress: turns accepted k-slices into skewed WEST/NORTH wavefronts and sequences clear/drain/done.
// Latency: lane i sees a beat accepted in cycle c at cycle c+1+i; clear/drain/done are registered one-cycle pulses.
// Backpressure: in_ready is high only while streaming; the mesh side has no backpressure and consumes every cycle.
module pe_array_feeder #(
   parameter int W      = 8,
   parameter int T      = 4,
   parameter int K_MAX  = 256,
   parameter int KW     = $clog2(K_MAX + 1),
   parameter int PE_LAT = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   pe_array_feeder_if.slave  up,
   output logic [T*W-1:0]    a_in_row,
   output logic [T-1:0]      a_in_valid,
   output logic [T*W-1:0]    b_in_col,
   output logic [T-1:0]      b_in_valid,
   output logic              acc_clear_block,
   output logic              drain_pulse,
   output logic              busy,
   output logic              done
);

   typedef enum logic [2:0] {IDLE, CLEAR, STREAM, FLUSH, DRAIN, DONE} state_t;

   // Bubbles needed for the last beat to cross the skew and finish its MAC, then the serpentine drain length.
   localparam int FLUSH_LEN = T - 1 + PE_LAT;
   localparam int DRAIN_LEN = T * T;
   localparam int CW        = $clog2(FLUSH_LEN + DRAIN_LEN + 1);
   localparam logic [KW-1:0] K_CAP = KW'(K_MAX);

   state_t        state;
   logic [KW-1:0] k_eff;
   logic [KW-1:0] k_cnt;
   logic [CW-1:0] ph_cnt;
   logic          accept;

   assign up.in_ready = (state == STREAM);
   assign busy        = (state != IDLE);
   assign accept      = (state == STREAM) && up.in_valid;

   // Block sequencer: state, beat counter, phase timer and the registered control pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= IDLE;
         k_eff           <= '0;
         k_cnt           <= '0;
         ph_cnt          <= '0;
         acc_clear_block <= 1'b0;
         drain_pulse     <= 1'b0;
         done            <= 1'b0;
      end else begin
         acc_clear_block <= 1'b0;
         drain_pulse     <= 1'b0;
         done            <= 1'b0;
         case (state)
            IDLE: begin
               // A zero-length block carries no work, so it never leaves IDLE.
               if (up.start && (up.k_len != '0)) begin
                  k_eff           <= (up.k_len > K_CAP) ? K_CAP : up.k_len;
                  k_cnt           <= '0;
                  acc_clear_block <= 1'b1;
                  state           <= CLEAR;
               end
            end
            CLEAR: state <= STREAM;
            STREAM: begin
               if (accept) begin
                  k_cnt <= k_cnt + KW'(1);
                  if (k_cnt == k_eff - KW'(1)) begin
                     ph_cnt <= CW'(FLUSH_LEN - 1);
                     state  <= FLUSH;
                  end
               end
            end
            FLUSH: begin
               if (ph_cnt == '0) begin
                  ph_cnt      <= CW'(DRAIN_LEN - 1);
                  drain_pulse <= 1'b1;
                  state       <= DRAIN;
               end else begin
                  ph_cnt <= ph_cnt - CW'(1);
               end
            end
            DRAIN: begin
               if (ph_cnt == '0) begin
                  done  <= 1'b1;
                  state <= DONE;
               end else begin
                  ph_cnt <= ph_cnt - CW'(1);
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   for (genvar i = 0; i < T; i++) begin : g_lane
      logic [W-1:0] a_sr [0:i];
      logic [W-1:0] b_sr [0:i];
      logic [i:0]   av_sr;
      logic [i:0]   bv_sr;

      // Lane i delay line (stage 0 is the output register for lane 0); non-accept cycles shift in a zero bubble.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            for (int s = 0; s <= i; s++) begin
               a_sr[s] <= '0;
               b_sr[s] <= '0;
            end
            av_sr <= '0;
            bv_sr <= '0;
         end else begin
            a_sr[0]  <= accept ? up.a_vec[i*W +: W] : '0;
            b_sr[0]  <= accept ? up.b_vec[i*W +: W] : '0;
            av_sr[0] <= accept;
            bv_sr[0] <= accept;
            for (int s = 1; s <= i; s++) begin
               a_sr[s]  <= a_sr[s-1];
               b_sr[s]  <= b_sr[s-1];
               av_sr[s] <= av_sr[s-1];
               bv_sr[s] <= bv_sr[s-1];
            end
         end
      end

      assign a_in_row[i*W +: W] = a_sr[i];
      assign b_in_col[i*W +: W] = b_sr[i];
      assign a_in_valid[i]      = av_sr[i];
      assign b_in_valid[i]      = bv_sr[i];
   end

endmodule

// File: tb/tb_pe_array_feeder.sv
// Bench for pe_array_feeder: directed blocks from the test plan plus randomized blocks vs a cycle-stamp model.
// Model: each accepted beat is stamped with its cycle; lane i expects it at stamp+1+i, control pulses at derived cycles.
// A second instance with K_MAX=4 checks k_len clamping.
module tb_pe_array_feeder;
   localparam int W      = 8;
   localparam int T      = 4;
   localparam int K_MAX  = 256;
   localparam int KW     = 9;
   localparam int PE_LAT = 1;
   localparam int NCYC   = 8192;
   localparam int BIG    = 32'h7fffffff;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   pe_array_feeder_if #(.W(W), .T(T), .KW(KW)) up ();
   pe_array_feeder_if #(.W(W), .T(T), .KW(3))  up4 ();

   logic [T*W-1:0] a_in_row, b_in_col, a4_row, b4_col;
   logic [T-1:0]   a_in_valid, b_in_valid, a4_vld, b4_vld;
   logic           acc_clear_block, drain_pulse, busy, done;
   logic           clr4, drn4, busy4, done4;

   pe_array_feeder #(.W(W), .T(T), .K_MAX(K_MAX), .KW(KW), .PE_LAT(PE_LAT)) dut (
      .clk(clk), .rst_n(rst_n), .up(up),
      .a_in_row(a_in_row), .a_in_valid(a_in_valid), .b_in_col(b_in_col), .b_in_valid(b_in_valid),
      .acc_clear_block(acc_clear_block), .drain_pulse(drain_pulse), .busy(busy), .done(done));

   pe_array_feeder #(.W(W), .T(T), .K_MAX(4), .KW(3), .PE_LAT(PE_LAT)) dut_k4 (
      .clk(clk), .rst_n(rst_n), .up(up4),
      .a_in_row(a4_row), .a_in_valid(a4_vld), .b_in_col(b4_col), .b_in_valid(b4_vld),
      .acc_clear_block(clr4), .drain_pulse(drn4), .busy(busy4), .done(done4));

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   // Reference model state: accepted-beat history and the block's time windows.
   bit             h_v [NCYC];
   logic [T*W-1:0] h_a [NCYC];
   logic [T*W-1:0] h_b [NCYC];
   int m_act_from, m_act_to, m_str_from, m_str_to, m_clear, m_drain, m_done, m_left;
   bit e_busy, e_rdy;

   int obs_drain, obs_done;
   bit cap_on;
   logic [W-1:0] lane2_q [$];
   int k4_n;
   bit k4_prev_acc, k4_flush_ok;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, got, exp, cyc);
      end
   endtask

   task automatic model_reset();
      for (int c = 0; c < NCYC; c++) begin
         h_v[c] = 1'b0;
         h_a[c] = '0;
         h_b[c] = '0;
      end
      m_act_from = BIG; m_act_to = -1;
      m_str_from = BIG; m_str_to = -1;
      m_clear = -1; m_drain = -1; m_done = -1; m_left = 0;
   endtask

   task automatic check_outputs();
      logic [T*W-1:0] ea, eb;
      logic [T-1:0]   eav, ebv;
      ea = '0; eb = '0; eav = '0; ebv = '0;
      e_busy = (cyc >= m_act_from) && (cyc <= m_act_to);
      e_rdy  = (cyc >= m_str_from) && (cyc <= m_str_to);
      for (int i = 0; i < T; i++) begin
         int idx;
         idx = cyc - 1 - i;
         if (idx >= 0 && h_v[idx]) begin
            eav[i] = 1'b1;
            ebv[i] = 1'b1;
            ea[i*W +: W] = h_a[idx][i*W +: W];
            eb[i*W +: W] = h_b[idx][i*W +: W];
         end
      end
      chk("a_in_valid", a_in_valid, eav);
      chk("b_in_valid", b_in_valid, ebv);
      chk("a_in_row", a_in_row, ea);
      chk("b_in_col", b_in_col, eb);
      chk("busy", busy, e_busy);
      chk("in_ready", up.in_ready, e_rdy);
      chk("acc_clear_block", acc_clear_block, cyc == m_clear);
      chk("drain_pulse", drain_pulse, cyc == m_drain);
      chk("done", done, cyc == m_done);
   endtask

   task automatic model_update(input logic st, input logic [KW-1:0] kl, input logic v,
                               input logic [T*W-1:0] a, input logic [T*W-1:0] b);
      if (e_rdy && v) begin
         h_v[cyc] = 1'b1;
         h_a[cyc] = a;
         h_b[cyc] = b;
         m_left--;
         if (m_left == 0) begin
            m_str_to = cyc;
            m_drain  = cyc + T + PE_LAT;
            m_done   = m_drain + T * T;
            m_act_to = m_done;
         end
      end
      if (!e_busy && st && kl != 0) begin
         m_act_from = cyc + 1; m_act_to = BIG;
         m_clear    = cyc + 1;
         m_str_from = cyc + 2; m_str_to = BIG;
         m_left     = (int'(kl) > K_MAX) ? K_MAX : int'(kl);
         m_drain    = -1; m_done = -1;
      end
   endtask

   task automatic tick(input logic st, input logic [KW-1:0] kl, input logic v,
                       input logic [T*W-1:0] a, input logic [T*W-1:0] b);
      bit acc4;
      up.start = st; up.k_len = kl; up.in_valid = v; up.a_vec = a; up.b_vec = b;
      @(negedge clk);
      check_outputs();
      model_update(st, kl, v, a, b);
      if (drain_pulse && obs_drain < 0) obs_drain = cyc;
      if (done && obs_done < 0) obs_done = cyc;
      if (cap_on && a_in_valid[2]) lane2_q.push_back(a_in_row[2*W +: W]);
      acc4 = up4.in_valid && up4.in_ready;
      if (k4_prev_acc && k4_n == 4) k4_flush_ok = !up4.in_ready && busy4;
      if (acc4) k4_n++;
      k4_prev_acc = acc4;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic idle(input int n);
      for (int c = 0; c < n; c++) tick(1'b0, '0, 1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom});
   endtask

   // Runs until the model's current block has finished; random start pulses while busy must be ignored.
   task automatic run_until_idle(input int vpct);
      int n;
      n = 0;
      while (!(m_act_to >= 0 && m_act_to != BIG && cyc > m_act_to) && !(m_act_from == BIG)) begin
         if (n >= 300) begin
            chk("block_timeout", 0, 1);
            break;
         end
         tick(1'($urandom_range(0, 9) == 0), KW'($urandom_range(0, 8)),
              1'($urandom_range(0, 99) < vpct), {$urandom, $urandom}, {$urandom, $urandom});
         n++;
      end
      tick(1'b0, '0, 1'b0, '0, '0);
   endtask

   task automatic do_reset();
      up.start = 0; up.k_len = '0; up.in_valid = 0; up.a_vec = '0; up.b_vec = '0;
      up4.start = 0; up4.k_len = '0; up4.in_valid = 0; up4.a_vec = '0; up4.b_vec = '0;
      rst_n = 1'b0;
      model_reset();
      @(negedge clk);
      chk("rst_a_in_valid", a_in_valid, '0);
      chk("rst_b_in_valid", b_in_valid, '0);
      chk("rst_a_in_row", a_in_row, '0);
      chk("rst_b_in_col", b_in_col, '0);
      chk("rst_ctrl", {acc_clear_block, drain_pulse, done, busy, up.in_ready}, '0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      cyc += 2;
   endtask

   task automatic pattern_block();
      logic [T*W-1:0] a;
      logic [W-1:0] l2 [3];
      bit pat [4];
      int bi;
      l2[0] = 8'h11; l2[1] = 8'h22; l2[2] = 8'h33;
      pat[0] = 1; pat[1] = 0; pat[2] = 1; pat[3] = 1;
      lane2_q.delete();
      cap_on = 1'b1;
      tick(1'b1, KW'(3), 1'b0, '0, '0);
      tick(1'b0, '0, 1'b1, {$urandom, $urandom}, {$urandom, $urandom});
      bi = 0;
      for (int c = 0; c < 4; c++) begin
         a = {$urandom, $urandom};
         if (pat[c]) begin
            a[2*W +: W] = l2[bi];
            bi++;
         end
         tick(1'b0, '0, pat[c], a, {$urandom, $urandom});
      end
      tick(1'b1, KW'(5), 1'b0, '0, '0);
      run_until_idle(50);
      cap_on = 1'b0;
      chk("lane2_count", lane2_q.size(), 3);
      for (int i = 0; i < 3; i++) chk("lane2_data", (i < lane2_q.size()) ? lane2_q[i] : 'x, l2[i]);
   endtask

   initial begin
      int s;
      obs_drain = -1; obs_done = -1; cap_on = 0; k4_n = 0; k4_prev_acc = 0; k4_flush_ok = 0;
      @(posedge clk);
      #1;
      do_reset();
      idle(10);

      // Back-to-back k=3 block with in_valid held high.
      s = cyc; obs_drain = -1; obs_done = -1;
      tick(1'b1, KW'(3), 1'b1, {$urandom, $urandom}, {$urandom, $urandom});
      run_until_idle(100);
      chk("drain_offset", obs_drain - s, 9);
      chk("done_offset", obs_done - s, 25);

      // Gapped block with a restart pulse inside it.
      pattern_block();

      // Zero-length start from IDLE is ignored.
      tick(1'b1, '0, 1'b1, {$urandom, $urandom}, {$urandom, $urandom});
      idle(3);

      // Reset in the middle of streaming, then a fresh block.
      tick(1'b1, KW'(5), 1'b0, '0, '0);
      tick(1'b0, '0, 1'b0, '0, '0);
      tick(1'b0, '0, 1'b1, {$urandom, $urandom}, {$urandom, $urandom});
      tick(1'b0, '0, 1'b1, {$urandom, $urandom}, {$urandom, $urandom});
      obs_drain = -1; obs_done = -1;
      do_reset();
      idle(30);
      chk("no_drain_after_rst", obs_drain, -1);
      chk("no_done_after_rst", obs_done, -1);
      pattern_block();

      // Randomized blocks.
      for (int b = 0; b < 20; b++) begin
         idle($urandom_range(0, 3));
         tick(1'b1, KW'($urandom_range(1, 9)), 1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom});
         run_until_idle($urandom_range(30, 100));
      end

      // Clamping instance: k_len=7 against K_MAX=4.
      k4_n = 0; k4_prev_acc = 0; k4_flush_ok = 0;
      up4.k_len = 3'd7; up4.in_valid = 1'b1; up4.a_vec = {$urandom, $urandom}; up4.b_vec = {$urandom, $urandom};
      up4.start = 1'b1;
      tick(1'b0, '0, 1'b0, '0, '0);
      up4.start = 1'b0;
      for (int c = 0; c < 40; c++) tick(1'b0, '0, 1'b0, '0, '0);
      chk("k4_beats", k4_n, 4);
      chk("k4_flush_entry", k4_flush_ok, 1);
      chk("k4_idle_at_end", busy4, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end
endmodule
